// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory write arbiter:
// arbiter state encoding, one-hot grant constants and a grant helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // One-hot owner for a given arbiter state; anything other than an OWN
  // state means nobody holds the memory port.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    logic [1:0] g;
    g = GRANT_NONE;
    case (st)
      OWN0:    g = GRANT_0;
      OWN1:    g = GRANT_1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_wr_arbiter_rr_sel2.sv
// Two-input round-robin select. A lone request wins outright; when both
// request, the one that did not own the port last time wins.
module rr_sel2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  // Pick the winning requester index from the request pair and history.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Packet-level arbiter that multiplexes two AXI-Stream write requesters onto
// one memory write stream. Ownership is granted at packet boundaries and held
// until the owner's tlast beat is accepted downstream. One IDLE cycle separates
// consecutive packets.
// Optional feature: define MEM_WR_ARB_PKT_CNT_EN to add per-requester packet
// counters pkt_cnt0/pkt_cnt1.
module mem_wr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,

  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,

  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,

  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,

  output logic [1:0]              grant,
  output logic                    busy
`ifdef MEM_WR_ARB_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1
`endif
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_owner;
  logic       winner;
  logic       any_req;
  logic       xfer_last;

  // Elaboration-time sanity hook: stream width must be whole bytes and the
  // counter width at least one bit; a bad setting leaves this block in place
  // as a visible marker in the elaborated hierarchy.
  if (((DATA_WIDTH % 8) != 0) || (CNT_WIDTH < 1)) begin : g_bad_params
  end

  assign any_req = s00_axis_tvalid | s01_axis_tvalid;

  rr_sel2 u_rr_sel2 (
    .req        ({s01_axis_tvalid, s00_axis_tvalid}),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // Current owner's final beat is accepted downstream this cycle.
  assign xfer_last = m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;

  // State register; reset drops any packet in flight.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: arbitrate only from IDLE, release only on an accepted tlast.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = winner ? OWN1 : OWN0;
        end
      end
      OWN0: begin
        if (xfer_last) begin
          next_state = IDLE;
        end
      end
      OWN1: begin
        if (xfer_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Round-robin history: remember who finished the most recent packet.
  // Resetting to 1 lets requester 0 win the first tie.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      last_owner <= 1'b1;
    end else if (xfer_last) begin
      last_owner <= (state == OWN1);
    end
  end

  // Zero-latency datapath mux and ready steering; nothing moves in IDLE and
  // the non-owner is held off with tready low.
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    case (state)
      OWN0: begin
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        s00_axis_tready = m00_axis_tready;
      end
      OWN1: begin
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        s01_axis_tready = m00_axis_tready;
      end
      default: begin
        m00_axis_tvalid = 1'b0;
      end
    endcase
  end

  // Status outputs derived directly from the owner state.
  always_comb begin
    grant = grant_of(state);
    busy  = (state == OWN0) || (state == OWN1);
  end

`ifdef MEM_WR_ARB_PKT_CNT_EN
  // Per-requester completed-packet counters, wrapping naturally at full scale.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (xfer_last) begin
      if (state == OWN0) begin
        pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end
      if (state == OWN1) begin
        pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Directed self-checking bench for mem_wr_arbiter. Counter checks are built
// only when MEM_WR_ARB_PKT_CNT_EN is defined.
module tb_mem_wr_arbiter;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          axis_aclk;
  logic          axis_aresetn;
  logic [DW-1:0] s00_axis_tdata;
  logic [3:0]    s00_axis_tstrb;
  logic          s00_axis_tvalid;
  logic          s00_axis_tlast;
  logic          s00_axis_tready;
  logic [DW-1:0] s01_axis_tdata;
  logic [3:0]    s01_axis_tstrb;
  logic          s01_axis_tvalid;
  logic          s01_axis_tlast;
  logic          s01_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [3:0]    m00_axis_tstrb;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic          m00_axis_tready;
  logic [1:0]    grant;
  logic          busy;
`ifdef MEM_WR_ARB_PKT_CNT_EN
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;
`endif

  int checks;
  int failures;

  mem_wr_arbiter #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .axis_aclk       (axis_aclk),
    .axis_aresetn    (axis_aresetn),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .grant           (grant),
    .busy            (busy)
`ifdef MEM_WR_ARB_PKT_CNT_EN
    ,
    .pkt_cnt0        (pkt_cnt0),
    .pkt_cnt1        (pkt_cnt1)
`endif
  );

  // 100 MHz clock
  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  // Hard stop in case something stalls the stimulus
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic l0,
                               input logic v1, input logic [7:0] d1, input logic l1,
                               input logic rdy);
    s00_axis_tvalid = v0;
    s00_axis_tdata  = {24'h0, d0};
    s00_axis_tlast  = l0;
    s01_axis_tvalid = v1;
    s01_axis_tdata  = {24'h0, d1};
    s01_axis_tlast  = l1;
    m00_axis_tready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic pulse_reset();
    axis_aresetn = 1'b0;
    #2;
    axis_aresetn = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [7:0] alt_data [4];
    logic       rdy_seq  [3];
`ifdef MEM_WR_ARB_PKT_CNT_EN
    logic [1:0] cnt_exp  [5];
`endif
    checks   = 0;
    failures = 0;
    alt_data = '{8'h11, 8'h22, 8'h11, 8'h22};
    rdy_seq  = '{1'b0, 1'b0, 1'b1};
    s00_axis_tstrb = 4'hF;
    s01_axis_tstrb = 4'h3;

    // Reset with both requesters shouting: nothing may be granted
    axis_aresetn = 1'b0;
    applyStimulus(1, 8'hEE, 1, 1, 8'hDD, 1, 1);
    repeat (2) @(posedge axis_aclk);
    #1;
    checkOutput("rst_grant", {30'h0, grant}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_m_valid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("rst_s0_ready", {31'h0, s00_axis_tready}, 32'h0);
    checkOutput("rst_s1_ready", {31'h0, s01_axis_tready}, 32'h0);
`ifdef MEM_WR_ARB_PKT_CNT_EN
    checkOutput("rst_cnt0", {30'h0, pkt_cnt0}, 32'h0);
    checkOutput("rst_cnt1", {30'h0, pkt_cnt1}, 32'h0);
`endif
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    next_cycle();

    // Three-beat packet from requester 0
    applyStimulus(1, 8'hA1, 0, 0, 8'h00, 0, 1);
    #1;
    checkOutput("p3_idle_grant", {30'h0, grant}, 32'h0);
    checkOutput("p3_idle_valid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("p3_idle_s0rdy", {31'h0, s00_axis_tready}, 32'h0);
    next_cycle();
    #1;
    checkOutput("p3_grant", {30'h0, grant}, 32'h1);
    checkOutput("p3_busy", {31'h0, busy}, 32'h1);
    checkOutput("p3_b1_data", m00_axis_tdata, 32'hA1);
    checkOutput("p3_b1_valid", {31'h0, m00_axis_tvalid}, 32'h1);
    checkOutput("p3_b1_last", {31'h0, m00_axis_tlast}, 32'h0);
    checkOutput("p3_strb", {28'h0, m00_axis_tstrb}, 32'hF);
    checkOutput("p3_s0rdy", {31'h0, s00_axis_tready}, 32'h1);
    next_cycle();
    applyStimulus(1, 8'hA2, 0, 0, 8'h00, 0, 1);
    #1;
    checkOutput("p3_b2_data", m00_axis_tdata, 32'hA2);
    next_cycle();
    applyStimulus(1, 8'hA3, 1, 0, 8'h00, 0, 1);
    #1;
    checkOutput("p3_b3_data", m00_axis_tdata, 32'hA3);
    checkOutput("p3_b3_last", {31'h0, m00_axis_tlast}, 32'h1);
    next_cycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    #1;
    checkOutput("p3_end_grant", {30'h0, grant}, 32'h0);
    checkOutput("p3_end_busy", {31'h0, busy}, 32'h0);

    // Simultaneous single-beat requests alternate, requester 0 first after reset
    pulse_reset();
    applyStimulus(1, 8'h11, 1, 1, 8'h22, 1, 1);
    for (int c = 0; c < 8; c++) begin
      #1;
      checkOutput($sformatf("alt_valid_%0d", c), {31'h0, m00_axis_tvalid}, {31'h0, c[0]});
      if (c[0]) begin
        checkOutput($sformatf("alt_data_%0d", c), m00_axis_tdata, {24'h0, alt_data[c/2]});
      end
      next_cycle();
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Requester 1 under downstream backpressure; requester 0 waits its turn
    applyStimulus(0, 8'h00, 0, 1, 8'h31, 0, 1);
    #1;
    checkOutput("bp_idle_grant", {30'h0, grant}, 32'h0);
    next_cycle();
    applyStimulus(1, 8'h99, 1, 1, 8'h31, 0, 1);
    #1;
    checkOutput("bp_grant", {30'h0, grant}, 32'h2);
    checkOutput("bp_b1_data", m00_axis_tdata, 32'h31);
    checkOutput("bp_b1_strb", {28'h0, m00_axis_tstrb}, 32'h3);
    checkOutput("bp_b1_s1rdy", {31'h0, s01_axis_tready}, 32'h1);
    checkOutput("bp_b1_s0rdy", {31'h0, s00_axis_tready}, 32'h0);
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 8'h99, 1, 1, 8'h32, 1, rdy_seq[c]);
      #1;
      checkOutput($sformatf("bp_b2_grant_%0d", c), {30'h0, grant}, 32'h2);
      checkOutput($sformatf("bp_b2_data_%0d", c), m00_axis_tdata, 32'h32);
      checkOutput($sformatf("bp_s1rdy_%0d", c), {31'h0, s01_axis_tready}, {31'h0, rdy_seq[c]});
      checkOutput($sformatf("bp_s0rdy_%0d", c), {31'h0, s00_axis_tready}, 32'h0);
      next_cycle();
    end
    applyStimulus(1, 8'h99, 1, 0, 8'h00, 0, 1);
    #1;
    checkOutput("bp_done_grant", {30'h0, grant}, 32'h0);
    next_cycle();
    #1;
    checkOutput("bp_s0_grant", {30'h0, grant}, 32'h1);
    checkOutput("bp_s0_data", m00_axis_tdata, 32'h99);
    next_cycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Owner stalls mid-packet while the other requester is valid
    applyStimulus(1, 8'h51, 0, 0, 8'h00, 0, 1);
    next_cycle();
    #1;
    checkOutput("hold_b1_data", m00_axis_tdata, 32'h51);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 8'h00, 0, 1, 8'h61, 1, 1);
      #1;
      checkOutput($sformatf("hold_grant_%0d", c), {30'h0, grant}, 32'h1);
      checkOutput($sformatf("hold_valid_%0d", c), {31'h0, m00_axis_tvalid}, 32'h0);
      checkOutput($sformatf("hold_s1rdy_%0d", c), {31'h0, s01_axis_tready}, 32'h0);
      next_cycle();
    end
    applyStimulus(1, 8'h52, 1, 1, 8'h61, 1, 1);
    #1;
    checkOutput("hold_last_grant", {30'h0, grant}, 32'h1);
    checkOutput("hold_last_data", m00_axis_tdata, 32'h52);
    next_cycle();
    applyStimulus(0, 8'h00, 0, 1, 8'h61, 1, 1);
    #1;
    checkOutput("hold_gap_grant", {30'h0, grant}, 32'h0);
    next_cycle();
    #1;
    checkOutput("hold_s1_grant", {30'h0, grant}, 32'h2);
    checkOutput("hold_s1_data", m00_axis_tdata, 32'h61);
    next_cycle();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Reset in the middle of a packet; history is cleared so requester 0 wins
    applyStimulus(1, 8'h70, 1, 0, 8'h00, 0, 1);
    next_cycle();
    next_cycle();
    applyStimulus(1, 8'h71, 0, 0, 8'h00, 0, 1);
    next_cycle();
    #1;
    checkOutput("mr_b1_data", m00_axis_tdata, 32'h71);
    next_cycle();
    applyStimulus(1, 8'h72, 0, 1, 8'h91, 1, 1);
    #1;
    checkOutput("mr_b2_grant", {30'h0, grant}, 32'h1);
    axis_aresetn = 1'b0;
    #1;
    checkOutput("mr_rst_grant", {30'h0, grant}, 32'h0);
    checkOutput("mr_rst_valid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("mr_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("mr_rst_s0rdy", {31'h0, s00_axis_tready}, 32'h0);
    #2;
    axis_aresetn = 1'b1;
    applyStimulus(1, 8'h81, 1, 1, 8'h91, 1, 1);
    next_cycle();
    #1;
    checkOutput("mr_rearb_grant", {30'h0, grant}, 32'h1);
    checkOutput("mr_rearb_data", m00_axis_tdata, 32'h81);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    next_cycle();

`ifdef MEM_WR_ARB_PKT_CNT_EN
    // Five single-beat packets from requester 1 with a 2-bit counter
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    pulse_reset();
    applyStimulus(0, 8'h00, 0, 1, 8'hC0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      checkOutput($sformatf("cnt_grant_%0d", i), {30'h0, grant}, 32'h2);
      next_cycle();
      #1;
      checkOutput($sformatf("cnt1_%0d", i), {30'h0, pkt_cnt1}, {30'h0, cnt_exp[i]});
      checkOutput($sformatf("cnt0_%0d", i), {30'h0, pkt_cnt0}, 32'h0);
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
